// File: rtl/t03_combat_arbiter.sv
// t03_combat_arbiter: round controller and hit arbiter between two player FSMs.
// Samples both players' action state and resting flag on each frame tick,
// resolves punches against blocks, applies damage, enforces hit-stun, runs
// the round timer and declares the winner.
// Optional feature macro: T03_COMBAT_COMBO_EN (per-player combo damage bonus).
module t03_combat_arbiter #(
   parameter logic [3:0]  MAX_HEALTH  = 4'd10,
   parameter logic [3:0]  PUNCH_DMG   = 4'd2,
   parameter logic [3:0]  CHIP_DMG    = 4'd1,
   parameter logic [7:0]  STUN_TICKS  = 8'd30,
   parameter logic [11:0] ROUND_TICKS = 12'd1800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        start,
   input  logic [1:0]  p1_state,
   input  logic        p1_resting,
   input  logic [1:0]  p2_state,
   input  logic        p2_resting,
   output logic [3:0]  p1_health,
   output logic [3:0]  p2_health,
   output logic        p1_hit,
   output logic        p2_hit,
   output logic [1:0]  round_st,
   output logic [1:0]  winner,
   output logic [11:0] round_time
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FIGHT = 2'b01,
      ST_OVER  = 2'b10
   } round_state_t;

   localparam logic [1:0] ACT_PUNCH = 2'b01;
   localparam logic [1:0] ACT_BLOCK = 2'b10;

   round_state_t state, state_n;

   logic [3:0]  h1_n, h2_n;
   logic        hit1_n, hit2_n;
   logic [1:0]  win_n;
   logic [11:0] time_n;
   logic [7:0]  stun1, stun2, stun1_n, stun2_n;
   logic        prev1, prev2, prev1_n, prev2_n;

   logic        active1, active2, guard1, guard2;
   logic        land1, land2;
   logic [3:0]  dmg_to_p1, dmg_to_p2;

`ifdef T03_COMBAT_COMBO_EN
   logic [1:0]  combo1, combo2, combo1_n, combo2_n;
`endif

   function automatic logic [3:0] sat_sub(input logic [3:0] h, input logic [3:0] d);
      return (h > d) ? (h - d) : 4'd0;
   endfunction

   assign active1 = (p1_state == ACT_PUNCH) && !p1_resting;
   assign active2 = (p2_state == ACT_PUNCH) && !p2_resting;
   assign guard1  = (p1_state == ACT_BLOCK) && !p1_resting;
   assign guard2  = (p2_state == ACT_BLOCK) && !p2_resting;

   // A punch lands only on a fresh rising edge of the attacker's active flag
   // while the attacker is not in hit-stun.
   assign land1 = active1 && !prev1 && (stun1 == 8'd0);
   assign land2 = active2 && !prev2 && (stun2 == 8'd0);

   // Damage each attacker would deal this tick, depending on victim's guard
   always_comb begin
      dmg_to_p2 = PUNCH_DMG;
      dmg_to_p1 = PUNCH_DMG;
`ifdef T03_COMBAT_COMBO_EN
      if (combo1 >= 2'd2) dmg_to_p2 = 4'(PUNCH_DMG + 4'd1);
      if (combo2 >= 2'd2) dmg_to_p1 = 4'(PUNCH_DMG + 4'd1);
`endif
      if (guard2) dmg_to_p2 = CHIP_DMG;
      if (guard1) dmg_to_p1 = CHIP_DMG;
   end

   // State register and all datapath registers; async active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         p1_health  <= MAX_HEALTH;
         p2_health  <= MAX_HEALTH;
         p1_hit     <= 1'b0;
         p2_hit     <= 1'b0;
         winner     <= 2'b00;
         round_time <= ROUND_TICKS;
         stun1      <= '0;
         stun2      <= '0;
         prev1      <= 1'b0;
         prev2      <= 1'b0;
`ifdef T03_COMBAT_COMBO_EN
         combo1     <= '0;
         combo2     <= '0;
`endif
      end else begin
         state      <= state_n;
         p1_health  <= h1_n;
         p2_health  <= h2_n;
         p1_hit     <= hit1_n;
         p2_hit     <= hit2_n;
         winner     <= win_n;
         round_time <= time_n;
         stun1      <= stun1_n;
         stun2      <= stun2_n;
         prev1      <= prev1_n;
         prev2      <= prev2_n;
`ifdef T03_COMBAT_COMBO_EN
         combo1     <= combo1_n;
         combo2     <= combo2_n;
`endif
      end
   end

   // Next-state and datapath update; everything holds unless tick is high,
   // except the hit pulses which default to zero every clock.
   always_comb begin
      state_n = state;
      h1_n    = p1_health;
      h2_n    = p2_health;
      hit1_n  = 1'b0;
      hit2_n  = 1'b0;
      win_n   = winner;
      time_n  = round_time;
      stun1_n = stun1;
      stun2_n = stun2;
      prev1_n = prev1;
      prev2_n = prev2;
`ifdef T03_COMBAT_COMBO_EN
      combo1_n = combo1;
      combo2_n = combo2;
`endif
      if (tick) begin
         prev1_n = active1;
         prev2_n = active2;
         unique case (state)
            ST_IDLE: begin
               h1_n   = MAX_HEALTH;
               h2_n   = MAX_HEALTH;
               time_n = ROUND_TICKS;
               if (start) begin
                  state_n = ST_FIGHT;
                  stun1_n = '0;
                  stun2_n = '0;
                  win_n   = 2'b00;
`ifdef T03_COMBAT_COMBO_EN
                  combo1_n = '0;
                  combo2_n = '0;
`endif
               end
            end
            ST_FIGHT: begin
               time_n = round_time - 12'd1;
               // A freshly loaded stun takes precedence over its countdown
               if (land1) begin
                  h2_n    = sat_sub(p2_health, dmg_to_p2);
                  hit2_n  = 1'b1;
                  stun2_n = STUN_TICKS;
               end else if (stun2 != 8'd0) begin
                  stun2_n = stun2 - 8'd1;
               end
               if (land2) begin
                  h1_n    = sat_sub(p1_health, dmg_to_p1);
                  hit1_n  = 1'b1;
                  stun1_n = STUN_TICKS;
               end else if (stun1 != 8'd0) begin
                  stun1_n = stun1 - 8'd1;
               end
`ifdef T03_COMBAT_COMBO_EN
               // Being hit breaks a combo before any landing can extend it
               if (land2 || (land1 && guard2)) combo1_n = '0;
               else if (land1 && (combo1 != 2'd3)) combo1_n = combo1 + 2'd1;
               if (land1 || (land2 && guard1)) combo2_n = '0;
               else if (land2 && (combo2 != 2'd3)) combo2_n = combo2 + 2'd1;
`endif
               // KO outranks timeout when both happen on the same tick
               if ((h1_n == 4'd0) || (h2_n == 4'd0)) begin
                  state_n = ST_OVER;
                  if ((h1_n == 4'd0) && (h2_n == 4'd0)) win_n = 2'b11;
                  else if (h2_n == 4'd0)                 win_n = 2'b01;
                  else                                   win_n = 2'b10;
               end else if (time_n == 12'd0) begin
                  state_n = ST_OVER;
                  if (h1_n > h2_n)      win_n = 2'b01;
                  else if (h2_n > h1_n) win_n = 2'b10;
                  else                  win_n = 2'b11;
               end
            end
            ST_OVER: begin
               if (start) begin
                  state_n = ST_FIGHT;
                  h1_n    = MAX_HEALTH;
                  h2_n    = MAX_HEALTH;
                  time_n  = ROUND_TICKS;
                  stun1_n = '0;
                  stun2_n = '0;
                  win_n   = 2'b00;
`ifdef T03_COMBAT_COMBO_EN
                  combo1_n = '0;
                  combo2_n = '0;
`endif
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   assign round_st = state;

endmodule

// File: tb/tb_t03_combat_arbiter.sv
// Directed self-checking bench for t03_combat_arbiter.
// Expected values are hand-computed; combo build (T03_COMBAT_COMBO_EN)
// changes only the round-3 damage expectations.
module tb_t03_combat_arbiter;

   localparam logic [1:0] INIT = 2'b00;
   localparam logic [1:0] PUN  = 2'b01;
   localparam logic [1:0] BLK  = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        start;
   logic [1:0]  p1_state, p2_state;
   logic        p1_resting, p2_resting;
   logic [3:0]  p1_health, p2_health;
   logic        p1_hit, p2_hit;
   logic [1:0]  round_st, winner;
   logic [11:0] round_time;

   int errors = 0;
   int checks = 0;

   t03_combat_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start      (start),
      .p1_state   (p1_state),
      .p1_resting (p1_resting),
      .p2_state   (p2_state),
      .p2_resting (p2_resting),
      .p1_health  (p1_health),
      .p2_health  (p2_health),
      .p1_hit     (p1_hit),
      .p2_hit     (p2_hit),
      .round_st   (round_st),
      .winner     (winner),
      .round_time (round_time)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge: one tick-high clock, returns at the next negedge
   task automatic step(input logic [1:0] s1, input logic r1,
                       input logic [1:0] s2, input logic r2, input logic st);
      p1_state   = s1;
      p1_resting = r1;
      p2_state   = s2;
      p2_resting = r2;
      start      = st;
      tick       = 1'b1;
      @(negedge clk);
      tick  = 1'b0;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(INIT, 1'b0, INIT, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; start = 1'b0;
      p1_state = INIT; p2_state = INIT; p1_resting = 1'b0; p2_resting = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_round_st", round_st, 0);
      chk("rst_p1_health", p1_health, 10);
      chk("rst_p2_health", p2_health, 10);
      chk("rst_hits", {p1_hit, p2_hit}, 0);
      chk("rst_winner", winner, 0);
      chk("rst_time", round_time, 1800);
      rst = 1'b0;
      @(negedge clk);

      // ---- Round 1: basic hits, stun, block, resting, timeout ----
      step(INIT, 0, INIT, 0, 1);
      chk("r1_start_st", round_st, 1);
      chk("r1_start_h", {p1_health, p2_health}, {4'd10, 4'd10});
      chk("r1_start_time", round_time, 1800);
      idle(1);
      chk("r1_time_1799", round_time, 1799);
      step(PUN, 0, INIT, 0, 0);
      chk("r1_punch_p2h", p2_health, 8);
      chk("r1_punch_p2hit", p2_hit, 1);
      chk("r1_punch_p1hit", p1_hit, 0);
      chk("r1_punch_time", round_time, 1798);
      @(negedge clk);
      chk("r1_hit_pulse_clear", p2_hit, 0);
      step(INIT, 0, PUN, 0, 0);
      chk("r1_stunned_p1h", p1_health, 10);
      chk("r1_stunned_p1hit", p1_hit, 0);
      step(PUN, 0, BLK, 0, 0);
      chk("r1_chip_p2h", p2_health, 7);
      chk("r1_chip_p2hit", p2_hit, 1);
      idle(1);
      step(PUN, 1, INIT, 0, 0);
      chk("r1_resting_p2h", p2_health, 7);
      chk("r1_resting_p2hit", p2_hit, 0);
      step(PUN, 0, INIT, 0, 0);
      chk("r1_after_rest_p2h", p2_health, 5);
      idle(29);
      step(INIT, 0, PUN, 0, 0);
      chk("r1_stun_last_tick_p1h", p1_health, 10);
      idle(1);
      step(INIT, 0, PUN, 0, 0);
      chk("r1_stun_expired_p1h", p1_health, 8);
      chk("r1_stun_expired_p1hit", p1_hit, 1);
      chk("r1_time_1761", round_time, 1761);
      idle(1);
      step(INIT, 0, PUN, 0, 0);
      chk("r1_p1h_6", p1_health, 6);
      idle(30);
      step(PUN, 0, BLK, 0, 0);
      chk("r1_p2h_4", p2_health, 4);
      chk("r1_time_1728", round_time, 1728);
      idle(1727);
      chk("r1_pre_timeout_st", round_st, 1);
      chk("r1_pre_timeout_time", round_time, 1);
      idle(1);
      chk("r1_timeout_st", round_st, 2);
      chk("r1_timeout_time", round_time, 0);
      chk("r1_timeout_winner", winner, 1);
      chk("r1_timeout_h", {p1_health, p2_health}, {4'd6, 4'd4});
      step(PUN, 0, INIT, 0, 0);
      chk("r1_frozen_st", round_st, 2);
      chk("r1_frozen_p2h", p2_health, 4);
      chk("r1_frozen_p2hit", p2_hit, 0);
      chk("r1_frozen_time", round_time, 0);

      // ---- Round 2: simultaneous hits down to double KO ----
      step(INIT, 0, INIT, 0, 1);
      chk("r2_start_st", round_st, 1);
      chk("r2_start_h", {p1_health, p2_health}, {4'd10, 4'd10});
      chk("r2_start_time", round_time, 1800);
      chk("r2_start_winner", winner, 0);
      for (int k = 0; k < 4; k++) begin
         step(PUN, 0, PUN, 0, 0);
         chk("r2_double_h", {p1_health, p2_health}, {4'(8 - 2 * k), 4'(8 - 2 * k)});
         chk("r2_double_hits", {p1_hit, p2_hit}, 2'b11);
         idle(30);
      end
      step(PUN, 0, PUN, 0, 0);
      chk("r2_ko_h", {p1_health, p2_health}, 0);
      chk("r2_ko_st", round_st, 2);
      chk("r2_ko_winner", winner, 3);
      chk("r2_ko_hits", {p1_hit, p2_hit}, 2'b11);

      // ---- Round 3: consecutive unblocked hits, tick-low hold, saturation ----
      step(INIT, 0, INIT, 0, 1);
      chk("r3_start_h", {p1_health, p2_health}, {4'd10, 4'd10});
      chk("r3_start_winner", winner, 0);
      step(PUN, 0, INIT, 0, 0);
      chk("r3_hit1_p2h", p2_health, 8);
      idle(1);
      step(PUN, 0, INIT, 0, 0);
      chk("r3_hit2_p2h", p2_health, 6);
      idle(1);
      p1_state = PUN; p1_resting = 1'b0;
      repeat (3) @(negedge clk);
      chk("r3_tick_low_p2h", p2_health, 6);
      chk("r3_tick_low_p2hit", p2_hit, 0);
      chk("r3_tick_low_time", round_time, 1796);
      step(PUN, 0, INIT, 0, 0);
`ifdef T03_COMBAT_COMBO_EN
      chk("r3_hit3_p2h", p2_health, 3);
`else
      chk("r3_hit3_p2h", p2_health, 4);
`endif
      chk("r3_hit3_p2hit", p2_hit, 1);
      idle(1);
      step(PUN, 0, BLK, 0, 0);
`ifdef T03_COMBAT_COMBO_EN
      chk("r3_chip_p2h", p2_health, 2);
`else
      chk("r3_chip_p2h", p2_health, 3);
`endif
      idle(1);
      step(PUN, 0, INIT, 0, 0);
`ifdef T03_COMBAT_COMBO_EN
      chk("r3_ko_p2h", p2_health, 0);
      chk("r3_ko_st", round_st, 2);
      chk("r3_ko_winner", winner, 1);
`else
      chk("r3_p2h_1", p2_health, 1);
      chk("r3_still_fight", round_st, 1);
      idle(1);
      step(PUN, 0, INIT, 0, 0);
      chk("r3_sat_p2h", p2_health, 0);
      chk("r3_sat_st", round_st, 2);
      chk("r3_sat_winner", winner, 1);
`endif

      // ---- Round 4: asynchronous reset mid-round ----
      step(INIT, 0, INIT, 0, 1);
      chk("r4_start_st", round_st, 1);
      step(PUN, 0, INIT, 0, 0);
      chk("r4_p2h", p2_health, 8);
      #2 rst = 1'b1;
      #1;
      chk("r4_async_st", round_st, 0);
      chk("r4_async_p2h", p2_health, 10);
      chk("r4_async_time", round_time, 1800);
      chk("r4_async_p2hit", p2_hit, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
